// File: rtl/alien_hit_ctrl.sv
// alien_hit_ctrl: collision detection, alive tracking and march-down timing for a
// five-alien row. Commands to aliensMove are serialised: one clear or one move at a time.
module alien_hit_ctrl #(
  parameter logic [7:0]  X0          = 8'd10,
  parameter logic [6:0]  Y0          = 7'd10,
  parameter int unsigned ALIEN_W     = 10,
  parameter int unsigned ALIEN_H     = 8,
  parameter int unsigned ALIEN_GAP   = 4,
  parameter int unsigned STEP_Y      = 5,
  parameter int unsigned BOTTOM_Y    = 100,
  parameter int unsigned MOVE_PERIOD = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rocketValid,
  input  logic [7:0] rocketX,
  input  logic [6:0] rocketY,
  input  logic       cleared1,
  input  logic       cleared2,
  input  logic       cleared3,
  input  logic       cleared4,
  input  logic       cleared5,
  input  logic       moveDone,
  output logic       clear1,
  output logic       clear2,
  output logic       clear3,
  output logic       clear4,
  output logic       clear5,
  output logic       moveDown,
  output logic       rocketHit,
  output logic [4:0] aliveMask,
  output logic [6:0] blockY,
  output logic       allDead,
  output logic       reachedBottom
);

  localparam int unsigned NumAliens = 5;
  localparam int unsigned Pitch     = ALIEN_W + ALIEN_GAP;
  localparam int unsigned CntW      = (MOVE_PERIOD > 2) ? $clog2(MOVE_PERIOD) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(MOVE_PERIOD - 1);

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StMove
  } state_e;

  state_e state_q, state_d;

  logic [4:0]      alive_q;
  logic [6:0]      block_y_q;
  logic [2:0]      clr_idx_q;
  logic [CntW-1:0] move_cnt_q;
  logic            move_pending_q;
  logic            all_dead_q;
  logic            reached_bottom_q;
  logic            rocket_hit_q;

  // Collision and command-decision signals
  logic [8:0] x_lo [NumAliens];
  logic [8:0] x_hi [NumAliens];
  logic [7:0] y_lo;
  logic [7:0] y_hi;
  logic       y_in;
  logic [4:0] hit_vec;
  logic       hit_any;
  logic [2:0] hit_idx;
  logic [4:0] cleared_vec;
  logic       cleared_sel;
  logic [7:0] move_end;
  logic       move_ok;
  logic       move_req;
  logic       start_move;
  logic       hit_accept;
  logic       clear_ack;
  logic       move_ack;
  logic       timer_frozen;
  logic       timer_wrap;
  logic [4:0] alive_after_clear;
  logic [4:0] clear_vec;

  // Bounding-box comparators; sums are widened one bit so no bound can wrap.
  always_comb begin
    y_lo = {1'b0, block_y_q};
    y_hi = y_lo + 8'(ALIEN_H - 1);
    y_in = ({1'b0, rocketY} >= y_lo) && ({1'b0, rocketY} <= y_hi);
    for (int k = 0; k < NumAliens; k++) begin
      x_lo[k]    = {1'b0, X0} + 9'(k * Pitch);
      x_hi[k]    = x_lo[k] + 9'(ALIEN_W - 1);
      hit_vec[k] = rocketValid && y_in && alive_q[k] &&
                   ({1'b0, rocketX} >= x_lo[k]) && ({1'b0, rocketX} <= x_hi[k]);
    end
  end

  // Lowest-index hit wins if more than one comparator ever fires.
  always_comb begin
    hit_any = |hit_vec;
    hit_idx = 3'd0;
    for (int k = NumAliens - 1; k >= 0; k--) begin
      if (hit_vec[k]) begin
        hit_idx = 3'(k);
      end
    end
  end

  // Acknowledge selection, bottom-limit check and the event strobes shared by the processes below.
  always_comb begin
    cleared_vec       = {cleared5, cleared4, cleared3, cleared2, cleared1};
    cleared_sel       = cleared_vec[clr_idx_q];
    move_end          = {1'b0, block_y_q} + 8'(STEP_Y + ALIEN_H);
    move_ok           = (move_end <= 8'(BOTTOM_Y));
    hit_accept        = (state_q == StIdle) && hit_any;
    move_req          = (state_q == StIdle) && !hit_any && move_pending_q;
    start_move        = move_req && move_ok && !all_dead_q && !reached_bottom_q;
    clear_ack         = (state_q == StClear) && cleared_sel;
    move_ack          = (state_q == StMove) && moveDone;
    timer_frozen      = move_pending_q || all_dead_q || reached_bottom_q;
    timer_wrap        = !timer_frozen && (move_cnt_q == CntMax);
    alive_after_clear = alive_q & ~(5'b00001 << clr_idx_q);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: a hit always beats a pending move
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (hit_any) begin
          state_d = StClear;
        end else if (start_move) begin
          state_d = StMove;
        end
      end
      StClear: begin
        if (cleared_sel) begin
          state_d = StIdle;
        end
      end
      StMove: begin
        if (moveDone) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the registered state; at most one command is ever high
  always_comb begin
    clear_vec = 5'b00000;
    if (state_q == StClear) begin
      clear_vec = 5'b00001 << clr_idx_q;
    end
    clear1   = clear_vec[0];
    clear2   = clear_vec[1];
    clear3   = clear_vec[2];
    clear4   = clear_vec[3];
    clear5   = clear_vec[4];
    moveDown = (state_q == StMove);
  end

  // Latch the hit alien, emit the one-cycle rocket kill, retire aliens on acknowledge
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_idx_q    <= 3'd0;
      rocket_hit_q <= 1'b0;
      alive_q      <= 5'b11111;
      all_dead_q   <= 1'b0;
    end else begin
      rocket_hit_q <= hit_accept;
      if (hit_accept) begin
        clr_idx_q <= hit_idx;
      end
      if (clear_ack) begin
        alive_q    <= alive_after_clear;
        all_dead_q <= (alive_after_clear == 5'b00000);
      end
    end
  end

  // Block origin advances only when the redraw is acknowledged
  always_ff @(posedge clk) begin
    if (reset) begin
      block_y_q <= Y0;
    end else if (move_ack) begin
      block_y_q <= block_y_q + 7'(STEP_Y);
    end
  end

  // March timer; a pending request is consumed by the first idle cycle without a hit
  always_ff @(posedge clk) begin
    if (reset) begin
      move_cnt_q       <= '0;
      move_pending_q   <= 1'b0;
      reached_bottom_q <= 1'b0;
    end else begin
      if (!timer_frozen) begin
        move_cnt_q <= timer_wrap ? '0 : move_cnt_q + 1'b1;
      end
      if (timer_wrap) begin
        move_pending_q <= 1'b1;
      end else if (move_req) begin
        move_pending_q <= 1'b0;
      end
      if (move_req && !move_ok && !all_dead_q) begin
        reached_bottom_q <= 1'b1;
      end
    end
  end

  assign rocketHit     = rocket_hit_q;
  assign aliveMask     = alive_q;
  assign blockY        = block_y_q;
  assign allDead       = all_dead_q;
  assign reachedBottom = reached_bottom_q;

endmodule

// File: tb/tb_alien_hit_ctrl.sv
// Testbench for alien_hit_ctrl: directed rocket/ack stimulus, expected commands queued
// by the stimulus and checked by an independent negedge monitor.
module tb_alien_hit_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       rocketValid;
  logic [7:0] rocketX;
  logic [6:0] rocketY;
  logic [4:0] cleared_v;
  logic       moveDone;
  logic [4:0] clear_v;
  logic       moveDown;
  logic       rocketHit;
  logic [4:0] aliveMask;
  logic [6:0] blockY;
  logic       allDead;
  logic       reachedBottom;

  always #5 clk = ~clk;

  alien_hit_ctrl #(
    .MOVE_PERIOD(16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rocketValid  (rocketValid),
    .rocketX      (rocketX),
    .rocketY      (rocketY),
    .cleared1     (cleared_v[0]),
    .cleared2     (cleared_v[1]),
    .cleared3     (cleared_v[2]),
    .cleared4     (cleared_v[3]),
    .cleared5     (cleared_v[4]),
    .moveDone     (moveDone),
    .clear1       (clear_v[0]),
    .clear2       (clear_v[1]),
    .clear3       (clear_v[2]),
    .clear4       (clear_v[3]),
    .clear5       (clear_v[4]),
    .moveDown     (moveDown),
    .rocketHit    (rocketHit),
    .aliveMask    (aliveMask),
    .blockY       (blockY),
    .allDead      (allDead),
    .reachedBottom(reachedBottom)
  );

  // Expected command: {moveDown, clear5..clear1}, rocketHit alongside it, blockY at issue.
  typedef struct packed {
    logic [5:0] cmd;
    logic       hit;
    logic [6:0] y;
  } req_t;

  req_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [5:0] cmd, input logic hit, input logic [6:0] y);
    req_t r;
    r.cmd = cmd;
    r.hit = hit;
    r.y   = y;
    exp_q.push_back(r);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_clear"}, {27'd0, clear_v}, 0);
    check({tag, "_movedown"}, {31'd0, moveDown}, 0);
    check({tag, "_rockethit"}, {31'd0, rocketHit}, 0);
    check({tag, "_alive"}, {27'd0, aliveMask}, 32'h1f);
    check({tag, "_blocky"}, {25'd0, blockY}, 10);
    check({tag, "_alldead"}, {31'd0, allDead}, 0);
    check({tag, "_bottom"}, {31'd0, reachedBottom}, 0);
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    rocketValid = 1'b0;
    rocketX     = 8'd0;
    rocketY     = 7'd0;
    cleared_v   = 5'b0;
    moveDone    = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_move(input string name);
    int n = 0;
    while (moveDown !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    check(name, {31'd0, moveDown}, 1);
  endtask

  task automatic shoot(input logic [7:0] x, input logic [6:0] y);
    rocketValid = 1'b1;
    rocketX     = x;
    rocketY     = y;
    tick();
    rocketValid = 1'b0;
  endtask

  // Monitor: pops one expectation per newly presented command; also checks pulse width
  // and command exclusivity every cycle.
  logic [5:0] mon_cmd;
  logic [5:0] prev_cmd = 6'd0;
  logic       prev_hit = 1'b0;
  req_t       mon_r;

  always @(negedge clk) begin
    mon_cmd = {moveDown, clear_v};
    if (mon_cmd != 6'd0 && mon_cmd != prev_cmd) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_cmd: got %b, expected no command", mon_cmd);
      end else begin
        mon_r = exp_q.pop_front();
        check("cmd", {26'd0, mon_cmd}, {26'd0, mon_r.cmd});
        check("cmd_rockethit", {31'd0, rocketHit}, {31'd0, mon_r.hit});
        check("cmd_blocky", {25'd0, blockY}, {25'd0, mon_r.y});
      end
    end
    if (prev_hit) check("rockethit_width", {31'd0, rocketHit}, 0);
    if (mon_cmd != 6'd0) check("cmd_exclusive", $countones(mon_cmd), 1);
    prev_cmd = mon_cmd;
    prev_hit = rocketHit;
  end

  initial begin
    // Reset, first hit on alien 3, acknowledge
    do_reset();
    check_reset_vals("reset");
    push(6'b000100, 1'b1, 7'd10);
    shoot(8'd38, 7'd12);
    check("clear3_up", {27'd0, clear_v}, 32'h04);
    check("rockethit_up", {31'd0, rocketHit}, 1);
    tick();
    cleared_v = 5'b00100;
    tick();
    check("clear3_down", {27'd0, clear_v}, 0);
    check("alive_11011", {27'd0, aliveMask}, 32'h1b);
    // Dead alien 3 with its ack stuck high: no new request
    shoot(8'd40, 7'd12);
    cleared_v = 5'b0;

    // Gap, edge pixels and y limit
    shoot(8'd20, 7'd17);
    push(6'b000001, 1'b1, 7'd10);
    shoot(8'd19, 7'd17);
    tick();
    cleared_v = 5'b00001;
    tick();
    cleared_v = 5'b0;
    check("alive_11010", {27'd0, aliveMask}, 32'h1a);
    shoot(8'd76, 7'd17);
    shoot(8'd10, 7'd18);

    // Timer-driven move, then hits against the new origin
    push(6'b100000, 1'b0, 7'd10);
    wait_move("move1_seen");
    moveDone = 1'b1;
    tick();
    moveDone = 1'b0;
    check("move1_down", {31'd0, moveDown}, 0);
    check("blocky_15", {25'd0, blockY}, 15);
    shoot(8'd30, 7'd12);
    push(6'b000010, 1'b1, 7'd15);
    shoot(8'd30, 7'd15);
    cleared_v = 5'b00010;
    tick();
    cleared_v = 5'b0;
    check("alive_11000", {27'd0, aliveMask}, 32'h18);

    // Hit on the same edge the timer expires: clear first, move one edge after the ack
    do_reset();
    repeat (15) tick();
    push(6'b000001, 1'b1, 7'd10);
    push(6'b100000, 1'b0, 7'd10);
    shoot(8'd10, 7'd10);
    check("race_clear1", {27'd0, clear_v}, 32'h01);
    cleared_v = 5'b00001;
    tick();
    cleared_v = 5'b0;
    check("race_idle_clear", {27'd0, clear_v}, 0);
    check("race_idle_move", {31'd0, moveDown}, 0);
    tick();
    check("race_move", {31'd0, moveDown}, 1);
    moveDone = 1'b1;
    tick();
    moveDone = 1'b0;
    check("race_blocky", {25'd0, blockY}, 15);

    // March to the bottom: last legal move starts at y=85, the next request latches the limit
    do_reset();
    for (int i = 0; i < 16; i++) begin
      push(6'b100000, 1'b0, 7'(10 + 5 * i));
      wait_move("march_seen");
      moveDone = 1'b1;
      tick();
      moveDone = 1'b0;
      check("march_blocky", {25'd0, blockY}, 32'(15 + 5 * i));
    end
    repeat (40) tick();
    check("bottom_flag", {31'd0, reachedBottom}, 1);
    check("bottom_blocky", {25'd0, blockY}, 90);
    check("bottom_nomove", {31'd0, moveDown}, 0);

    // Clear every alien back to back, then no more moves
    do_reset();
    for (int k = 0; k < 5; k++) begin
      check("alldead_early", {31'd0, allDead}, 0);
      push(6'(1 << k), 1'b1, 7'd10);
      shoot(8'(10 + 14 * k), 7'd10);
      cleared_v = 5'(1 << k);
      tick();
      cleared_v = 5'b0;
    end
    check("alldead_mask", {27'd0, aliveMask}, 0);
    check("alldead_flag", {31'd0, allDead}, 1);
    repeat (40) tick();
    check("alldead_nomove", {31'd0, moveDown}, 0);

    // Reset in the middle of a clear
    do_reset();
    push(6'b001000, 1'b1, 7'd10);
    shoot(8'd52, 7'd10);
    check("midclear_clear4", {27'd0, clear_v}, 32'h08);
    reset = 1'b1;
    tick();
    check_reset_vals("midclear");
    reset = 1'b0;
    tick();
    tick();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alien_hit_ctrl.md
# alien_hit_ctrl

Controller that sits directly upstream of `aliensMove` and generates its `clear1..clear5` and `moveDown` commands. It holds the alive state of the five-alien row and detects rocket/alien collisions against each alien's bounding box. It runs the periodic march-down timer and tracks the block's vertical origin. It serialises clears and moves so that `aliensMove` only ever sees one command at a time.

## Interface
Parameters:
- `X0`, 8'd10: fixed x origin of alien 0.
- `Y0`, 7'd10: initial y origin of the block.
- `ALIEN_W`, 10: alien width in pixels.
- `ALIEN_H`, 8: alien height in pixels.
- `ALIEN_GAP`, 4: horizontal gap between adjacent aliens.
- `STEP_Y`, 5: pixels descended per move.
- `BOTTOM_Y`, 100: the block's bottom edge may not pass this row.
- `MOVE_PERIOD`, 25_000_000: cycles between move requests. Minimum 2.

Ports:
- `clk`  in  1  system clock. Single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `rocketValid`  in  1  rocket is in flight and its position is valid.
- `rocketX`  in  8  rocket x pixel.
- `rocketY`  in  7  rocket y pixel.
- `cleared1..cleared5`  in  1 each  `aliensMove` has finished erasing alien k.
- `moveDone`  in  1  `aliensMove` has finished the shift-down redraw.
- `clear1..clear5`  out  1 each  erase request for alien k. Level, held until acknowledged.
- `moveDown`  out  1  shift-down request. Level, held until `moveDone`.
- `rocketHit`  out  1  one-cycle pulse that kills the rocket.
- `aliveMask`  out  5  bit k-1 = alien k alive.
- `blockY`  out  7  current block y origin.
- `allDead`  out  1  asserted when `aliveMask == 0`.
- `reachedBottom`  out  1  sticky; a requested move would have crossed `BOTTOM_Y`.

## Operation
States: `IDLE`, `CLEAR`, `MOVE`.

Geometry:
- Alien k (k = 0..4) spans x in [X0+k*(ALIEN_W+ALIEN_GAP), X0+k*(ALIEN_W+ALIEN_GAP)+ALIEN_W-1].
- All aliens span y in [blockY, blockY+ALIEN_H-1].
- Default x spans: 10..19, 24..33, 38..47, 52..61, 66..75.
- All bound sums are computed at 9 bits (x) and 8 bits (y), so no comparison wraps.

Hit detection:
- Five parallel comparators plus the `aliveMask` bit.
- `hitK` = `rocketValid` AND rocket inside alien K's box AND alien K alive.
- Boxes never overlap. If more than one `hitK` is ever true, the lowest index wins.

State transitions:
- `IDLE` with any hit: go to `CLEAR`, latch K, raise `clearK` and pulse `rocketHit`. A hit has priority over a pending move.
- `IDLE` with no hit, `movePending` set, and `blockY+STEP_Y+ALIEN_H <= BOTTOM_Y`: go to `MOVE`, raise `moveDown`, clear `movePending`.
- `IDLE` with no hit, `movePending` set, and the bottom limit exceeded: set `reachedBottom`, clear `movePending`, stay in `IDLE`.
- `CLEAR`: hold `clearK`. When `clearedK` is 1, drop `clearK`, clear `aliveMask[K-1]`, return to `IDLE`. Other `cleared` inputs are ignored.
- `MOVE`: hold `moveDown`. When `moveDone` is 1, drop `moveDown`, set `blockY <= blockY+STEP_Y`, return to `IDLE`.

Move timer (`moveCnt`):
- Counts in every state.
- Frozen while `movePending`, `allDead` or `reachedBottom` is set.
- At `MOVE_PERIOD-1` it wraps to 0 and sets `movePending`.

Other rules:
- Rocket positions during `CLEAR` or `MOVE` are not evaluated and not queued.
- A `cleared` input stuck high is harmless. A dead alien is never re-requested, so `clearK` for a dead alien never asserts.
- `allDead` or `reachedBottom`: no further `moveDown`. Hits on remaining aliens are still processed.

## Timing
Reset values (synchronous, take effect on the next edge, override any state including mid-`CLEAR`/`MOVE`):
- state `IDLE`, `aliveMask = 5'b11111`, `blockY = Y0`.
- `clear1..5 = 0`, `moveDown = 0`, `rocketHit = 0`.
- `allDead = 0`, `reachedBottom = 0`, `moveCnt = 0`, `movePending = 0`.

Latencies:
- Hit sampled at edge N (state `IDLE`): `clearK` and `rocketHit` are high from N+1. `rocketHit` falls at N+2.
- `clearedK` sampled high at edge M: `clearK` is low and the `aliveMask` bit is cleared from M+1. The earliest next command is issued at M+2.
- `moveDone` sampled high at edge M: `moveDown` is low and `blockY` is updated from M+1.
- `movePending` is set at the edge where `moveCnt` = `MOVE_PERIOD-1`. `moveDown` rises one edge later if `IDLE` and no hit.

Other rules:
- `allDead` is registered and updates in the same cycle as `aliveMask`.
- `clearK` and `moveDown` are never high simultaneously. At most one `clearK` is high at a time.

## Test plan
Bench uses `MOVE_PERIOD` = 16.
- Reset, then `rocketValid=1`, `rocketX=38`, `rocketY=12` -> next cycle `clear3=1` and a 1-cycle `rocketHit`. Pulse `cleared3` -> `clear3` falls, `aliveMask=5'b11011`.
- `rocketX=20` (gap), then 19, then 76, all with `rocketY=17` -> no hit at 20 or 76. `clear1` at x=19. `rocketY=18` at x=10 -> no hit.
- Idle 16 cycles -> `moveDown` rises. `moveDone` pulse -> `moveDown` falls, `blockY=15`. The same rocket at y=12 no longer hits; y=15 hits.
- Hit and timer expiry on the same cycle -> `clearK` is issued first. `moveDown` follows 1 cycle after `clearedK` is sampled. Never both high.
- Repeat moves from `blockY=10` -> `moveDown` issued until `blockY=85`. The next request sets `reachedBottom=1`, no `moveDown`, timer frozen.
- Clear all five aliens -> `allDead=1`, no `moveDown` thereafter. Assert `reset` while in `CLEAR` -> all outputs at reset values next cycle.
